iram_loadable: RTL and testbench

Parametrised instruction memory for the single-cycle CPU. Fetch is a byte-addressed combinational read, with the word index taken from ADDR[ADDR_W-1:1].
It adds a byte-stream load port (valid/ready handshake) so that a program can be written at run time rather than only from a fixed reset image.
While a load is in progress the block asserts CPU_HOLD so that the core stalls fetch.

---
 rtl/iram_pkg.sv | 21 ++
 rtl/iram_ld_if.sv | 23 ++
 rtl/iram_byte_assembler.sv | 48 ++++
 rtl/iram_loadable.sv | 130 +++++++++++++
 tb/tb_iram_loadable.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/iram_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package iram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } iram_state_t;

    localparam int DATA_W_DEF     = 16;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

    // Bit width needed to count n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/iram_ld_if.sv
// Byte-stream load port of the instruction memory, plus the fetch stall request.
interface iram_ld_if #(
    parameter int ADDR_W = 8
);
    logic              LD_START;
    logic [ADDR_W-2:0] LD_COUNT;
    logic [7:0]        LD_BYTE;
    logic              LD_VALID;
    logic              LD_READY;
    logic              LD_DONE;
    logic              LD_ERR;
    logic              CPU_HOLD;

    modport master (
        output LD_START, LD_COUNT, LD_BYTE, LD_VALID,
        input  LD_READY, LD_DONE, LD_ERR, CPU_HOLD
    );

    modport slave (
        input  LD_START, LD_COUNT, LD_BYTE, LD_VALID,
        output LD_READY, LD_DONE, LD_ERR, CPU_HOLD
    );
endinterface

// File: rtl/iram_byte_assembler.sv
// Packs a most-significant-first byte stream into DATA_W-bit words.
module iram_byte_assembler
    import iram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    localparam int BPW = DATA_W / 8;
    localparam int CW  = clog2_min1(BPW);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            cnt <= '0;
        end else if (byte_valid) begin
            cnt <= (cnt == CW'(BPW - 1)) ? '0 : cnt + CW'(1);
        end
    end

    assign word_valid = byte_valid && (cnt == CW'(BPW - 1));

    generate
        if (BPW == 1) begin : g_single
            assign word = byte_in;
        end else begin : g_multi
            logic [DATA_W-9:0] hist;

            // The completed word is the held bytes followed by the current byte.
            assign word = {hist, byte_in};

            always_ff @(posedge CLK) begin
                if (RESET || clear) begin
                    hist <= '0;
                end else if (byte_valid) begin
                    hist <= word[DATA_W-9:0];
                end
            end
        end
    endgenerate
endmodule

// File: rtl/iram_loadable.sv
// Instruction memory with combinational fetch and a run-time byte-stream load port.
// Define IRAM_CHECKSUM_EN to require a trailing modulo-256 checksum byte per load.
module iram_loadable
    import iram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** (ADDR_W - 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              MISALIGN,
    iram_ld_if.slave          ld
);
    localparam int IW = ADDR_W - 1;

    iram_state_t       state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     ptr, cnt_cap, last_idx, rd_idx;
    logic [DATA_W-1:0] word;
    logic              start, xfer, asm_valid, word_valid, word_last, ck_phase;

    assign start     = (state == IDLE) && ld.LD_START;
    assign xfer      = (state == LOAD) && ld.LD_VALID;
    assign word_last = word_valid && (ptr == last_idx);

    // A count of 0 means a full load; larger counts are clamped so the pointer stays in range.
    always_comb begin
        last_idx = cnt_cap - IW'(1);
        if (cnt_cap == '0 || int'(cnt_cap) > DEPTH) last_idx = IW'(DEPTH - 1);
    end

    iram_byte_assembler #(.DATA_W(DATA_W)) u_asm (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear      (start),
        .byte_in    (ld.LD_BYTE),
        .byte_valid (asm_valid),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ld.LD_READY = 1'b0;
        ld.LD_DONE  = 1'b0;
        ld.CPU_HOLD = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                ld.LD_READY = 1'b1;
                ld.CPU_HOLD = 1'b1;
`ifdef IRAM_CHECKSUM_EN
                if (ck_phase && xfer) state_nxt = DONE;
`else
                if (word_last) state_nxt = DONE;
`endif
            end
            DONE: begin
                ld.LD_DONE  = 1'b1;
                ld.CPU_HOLD = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr     <= '0;
            cnt_cap <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (start) begin
                cnt_cap <= ld.LD_COUNT;
                ptr     <= '0;
            end
            if (word_valid) begin
                mem[ptr] <= word;
                if (!word_last) ptr <= ptr + IW'(1);
            end
        end
    end

`ifdef IRAM_CHECKSUM_EN
    logic [7:0] sum;
    logic       err;

    assign asm_valid = xfer && !ck_phase;
    assign ld.LD_ERR = err;

    // After the last word the next byte is the checksum and bypasses the assembler.
    always_ff @(posedge CLK) begin
        if (RESET || start) begin
            sum      <= '0;
            ck_phase <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (asm_valid) sum <= sum + ld.LD_BYTE;
            if (word_last) ck_phase <= 1'b1;
            if (ck_phase && xfer) begin
                ck_phase <= 1'b0;
                err      <= (sum + ld.LD_BYTE) != 8'h00;
            end
        end
    end
`else
    assign ck_phase  = 1'b0;
    assign asm_valid = xfer;
    assign ld.LD_ERR = 1'b0;
`endif

    assign rd_idx   = ADDR[ADDR_W-1:1];
    assign MISALIGN = ADDR[0];

    generate
        if (DEPTH < 2 ** IW) begin : g_partial
            assign Q = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;
        end else begin : g_full
            assign Q = mem[rd_idx];
        end
    endgenerate
endmodule

// File: tb/tb_iram_loadable.sv
// Directed bench for iram_loadable: reset image, loads, stalls, abort and checksum.
module tb_iram_loadable;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  ADDR;
    logic [15:0] Q;
    logic        MISALIGN;

    iram_ld_if #(.ADDR_W(8)) ld ();

    iram_loadable #(.DATA_W(16), .ADDR_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDR     (ADDR),
        .Q        (Q),
        .MISALIGN (MISALIGN),
        .ld       (ld)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] ld_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [15:0] e);
        ADDR = a;
        #1;
        check_eq($sformatf("q@%02h", a), {16'h0, Q}, {16'h0, e});
    endtask

    // Appends the byte that makes the modulo-256 sum of the stream zero.
    task automatic append_checksum();
`ifdef IRAM_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        foreach (ld_q[i]) s = s + ld_q[i];
        ld_q.push_back(8'h00 - s);
`endif
    endtask

    task automatic run_load(input logic [6:0] count, input bit toggle, input bit expect_err);
        int idx;
        int cyc;
        bit v;
        bit ph;
        @(posedge CLK); #1;
        ld.LD_START = 1'b1;
        ld.LD_COUNT = count;
        @(posedge CLK); #1;
        ld.LD_START = 1'b0;
        check_eq("hold_after_start", {31'h0, ld.CPU_HOLD}, 32'h1);
`ifdef IRAM_CHECKSUM_EN
        check_eq("err_cleared_on_start", {31'h0, ld.LD_ERR}, 32'h0);
`endif
        idx = 0;
        cyc = 0;
        ph  = 1'b1;
        while (idx < ld_q.size() && cyc < 4000) begin
            v  = toggle ? ph : 1'b1;
            ph = !ph;
            ld.LD_VALID = v;
            ld.LD_BYTE  = ld_q[idx];
            if (toggle) begin
                #1;
                check_eq("ready_in_load", {31'h0, ld.LD_READY}, 32'h1);
            end
            @(posedge CLK); #1;
            if (v) idx++;
            cyc++;
        end
        ld.LD_VALID = 1'b0;
        if (cyc >= 4000) check_eq("load_timeout", 32'h0, 32'h1);
        check_eq("done_pulse", {31'h0, ld.LD_DONE}, 32'h1);
        check_eq("ready_in_done", {31'h0, ld.LD_READY}, 32'h0);
        check_eq("hold_in_done", {31'h0, ld.CPU_HOLD}, 32'h1);
`ifdef IRAM_CHECKSUM_EN
        check_eq("ld_err", {31'h0, ld.LD_ERR}, {31'h0, expect_err});
`else
        check_eq("ld_err_tied", {31'h0, ld.LD_ERR}, 32'h0);
`endif
        @(posedge CLK); #1;
        check_eq("done_once", {31'h0, ld.LD_DONE}, 32'h0);
        check_eq("hold_released", {31'h0, ld.CPU_HOLD}, 32'h0);
    endtask

    initial begin
        RESET       = 1'b1;
        ADDR        = 8'h00;
        ld.LD_START = 1'b0;
        ld.LD_COUNT = '0;
        ld.LD_BYTE  = 8'h00;
        ld.LD_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        check_eq("rst_hold", {31'h0, ld.CPU_HOLD}, 32'h0);
        check_eq("rst_ready", {31'h0, ld.LD_READY}, 32'h0);
        check_eq("rst_done", {31'h0, ld.LD_DONE}, 32'h0);
        check_eq("rst_err", {31'h0, ld.LD_ERR}, 32'h0);
        read_chk(8'h00, 16'h0000);
        check_eq("misalign_0", {31'h0, MISALIGN}, 32'h0);
        read_chk(8'h02, 16'h0000);
        read_chk(8'h7E, 16'h0000);

        ld_q = '{8'hF0, 8'h01, 8'hF2, 8'h91};
        append_checksum();
        run_load(7'd2, 1'b0, 1'b0);
        read_chk(8'h00, 16'hF001);
        read_chk(8'h02, 16'hF291);
        read_chk(8'h04, 16'h0000);
        read_chk(8'h01, 16'hF001);
        check_eq("misalign_1", {31'h0, MISALIGN}, 32'h1);

        // Abort after three bytes of a two-word load.
        @(posedge CLK); #1;
        ld.LD_START = 1'b1;
        ld.LD_COUNT = 7'd2;
        @(posedge CLK); #1;
        ld.LD_START = 1'b0;
        ld.LD_VALID = 1'b1;
        ld.LD_BYTE = 8'hAB; @(posedge CLK); #1;
        ld.LD_BYTE = 8'hCD; @(posedge CLK); #1;
        ld.LD_BYTE = 8'hEF; @(posedge CLK); #1;
        ld.LD_VALID = 1'b0;
        read_chk(8'h00, 16'hABCD);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check_eq("abort_hold", {31'h0, ld.CPU_HOLD}, 32'h0);
        check_eq("abort_ready", {31'h0, ld.LD_READY}, 32'h0);
        read_chk(8'h00, 16'h0000);
        read_chk(8'h02, 16'h0000);

        ld_q = '{8'hF0, 8'h01, 8'hF2, 8'h91};
        append_checksum();
        run_load(7'd2, 1'b1, 1'b0);
        read_chk(8'h00, 16'hF001);
        read_chk(8'h02, 16'hF291);
        read_chk(8'h04, 16'h0000);

        ld_q = {};
        for (int w = 0; w < 128; w++) begin
            ld_q.push_back(8'(w));
            ld_q.push_back(8'(w) ^ 8'hA5);
        end
        append_checksum();
        run_load(7'd0, 1'b0, 1'b0);
        read_chk(8'h00, 16'h00A5);
        read_chk(8'h02, 16'h01A4);
        read_chk(8'h80, 16'h40E5);
        read_chk(8'hFE, 16'h7FDA);

`ifdef IRAM_CHECKSUM_EN
        ld_q = '{8'hF0, 8'h01, 8'h0F};
        run_load(7'd1, 1'b0, 1'b0);
        read_chk(8'h00, 16'hF001);
        ld_q = '{8'hF0, 8'h01, 8'h10};
        run_load(7'd1, 1'b0, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        check_eq("err_sticky", {31'h0, ld.LD_ERR}, 32'h1);
        ld_q = '{8'h12, 8'h34, 8'hBA};
        run_load(7'd1, 1'b0, 1'b0);
        read_chk(8'h00, 16'h1234);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
